// File: rtl/pipeline_run_controller_if.sv
// Command/status bundle between the debug UART path and pipeline_run_controller.
// Breakpoint signals are present only when PIPE_CTRL_BREAKPOINT_EN is defined.
interface pipeline_run_controller_if #(
  parameter int CMD_WIDTH       = 8,
  parameter int CYCLE_CNT_WIDTH = 32
);
  logic [CMD_WIDTH-1:0]       i_cmd;
  logic                       i_cmd_valid;
  logic                       i_load_done;
  logic                       i_program_finished;
  logic                       i_dump_done;
  logic                       o_cmd_ready;
  logic                       o_pipeline_enable;
  logic                       o_dump_request;
  logic [CYCLE_CNT_WIDTH-1:0] o_cycle_count;
  logic                       o_halted;
  logic                       o_bad_cmd;
`ifdef PIPE_CTRL_BREAKPOINT_EN
  logic [31:0]                i_pc;
  logic [31:0]                i_bp_addr;
  logic                       i_bp_valid;

  modport master (
    output i_cmd, i_cmd_valid, i_load_done, i_program_finished, i_dump_done,
           i_pc, i_bp_addr, i_bp_valid,
    input  o_cmd_ready, o_pipeline_enable, o_dump_request, o_cycle_count,
           o_halted, o_bad_cmd
  );

  modport slave (
    input  i_cmd, i_cmd_valid, i_load_done, i_program_finished, i_dump_done,
           i_pc, i_bp_addr, i_bp_valid,
    output o_cmd_ready, o_pipeline_enable, o_dump_request, o_cycle_count,
           o_halted, o_bad_cmd
  );
`else
  modport master (
    output i_cmd, i_cmd_valid, i_load_done, i_program_finished, i_dump_done,
    input  o_cmd_ready, o_pipeline_enable, o_dump_request, o_cycle_count,
           o_halted, o_bad_cmd
  );

  modport slave (
    input  i_cmd, i_cmd_valid, i_load_done, i_program_finished, i_dump_done,
    output o_cmd_ready, o_pipeline_enable, o_dump_request, o_cycle_count,
           o_halted, o_bad_cmd
  );
`endif
endinterface

// File: rtl/pipeline_run_controller.sv
// Debug-unit run controller: gates the pipeline clock-enable in continuous or step
// mode, counts enabled cycles and requests state dumps. Optional macro: PIPE_CTRL_BREAKPOINT_EN.
module pipeline_run_controller #(
  parameter int                   CMD_WIDTH       = 8,
  parameter int                   CYCLE_CNT_WIDTH = 32,
  parameter logic [CMD_WIDTH-1:0] CMD_CONTINUOUS  = 8'h43,
  parameter logic [CMD_WIDTH-1:0] CMD_STEP        = 8'h53,
  parameter logic [CMD_WIDTH-1:0] CMD_ABORT       = 8'h41
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  pipeline_run_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_DUMP      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [CYCLE_CNT_WIDTH-1:0] CNT_ONE = {{(CYCLE_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_CNT_WIDTH-1:0] CNT_MAX = {CYCLE_CNT_WIDTH{1'b1}};

  state_t                     state_r;
  state_t                     state_s;
  state_t                     ret_r;
  state_t                     ret_s;
  logic                       bad_s;
  logic                       is_cont_s;
  logic                       is_step_s;
  logic                       is_abort_s;
  logic                       bp_hit_s;
  logic                       enable_r;
  logic                       ready_r;
  logic                       dump_req_r;
  logic                       halted_r;
  logic                       bad_r;
  logic [CYCLE_CNT_WIDTH-1:0] count_r;

  assign is_cont_s  = bus.i_cmd_valid && (bus.i_cmd == CMD_CONTINUOUS);
  assign is_step_s  = bus.i_cmd_valid && (bus.i_cmd == CMD_STEP);
  assign is_abort_s = bus.i_cmd_valid && (bus.i_cmd == CMD_ABORT);

`ifdef PIPE_CTRL_BREAKPOINT_EN
  assign bp_hit_s = bus.i_bp_valid && (bus.i_pc == bus.i_bp_addr);
`else
  assign bp_hit_s = 1'b0;
`endif

  // Next-state, dump return target and command-reject decision
  always_comb begin
    state_s = state_r;
    ret_s   = ret_r;
    bad_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        bad_s = bus.i_cmd_valid;
        if (bus.i_load_done) begin
          state_s = S_READY;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READY: begin
        if (is_cont_s) begin
          state_s = S_RUN;
        end else if (is_step_s) begin
          state_s = S_STEP_WAIT;
        end else begin
          bad_s = bus.i_cmd_valid;
        end
      end
      S_RUN: begin
        bad_s = bus.i_cmd_valid;
        // Program end wins over a breakpoint hit in the same cycle
        if (bus.i_program_finished) begin
          state_s = S_DUMP;
          ret_s   = S_DONE;
        end else if (bp_hit_s) begin
          state_s = S_DUMP;
          ret_s   = S_STEP_WAIT;
        end else begin
          state_s = S_RUN;
        end
      end
      S_STEP_WAIT: begin
        // The halting step has already been dumped, so finish without another one
        if (bus.i_program_finished) begin
          state_s = S_DONE;
          bad_s   = bus.i_cmd_valid;
        end else if (is_step_s) begin
          state_s = S_STEP_EXEC;
        end else if (is_abort_s) begin
          state_s = S_DUMP;
          ret_s   = S_DONE;
        end else begin
          bad_s = bus.i_cmd_valid;
        end
      end
      S_STEP_EXEC: begin
        bad_s   = bus.i_cmd_valid;
        state_s = S_DUMP;
        if (bus.i_program_finished) begin
          ret_s = S_DONE;
        end else begin
          ret_s = S_STEP_WAIT;
        end
      end
      S_DUMP: begin
        bad_s = bus.i_cmd_valid;
        if (bus.i_dump_done) begin
          state_s = ret_r;
        end else begin
          state_s = S_DUMP;
        end
      end
      S_DONE: begin
        bad_s   = bus.i_cmd_valid;
        state_s = S_DONE;
      end
      default: begin
        state_s = S_IDLE;
        ret_s   = S_DONE;
      end
    endcase
  end

  // State register and outputs registered from the next state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= S_IDLE;
      ret_r      <= S_DONE;
      enable_r   <= 1'b0;
      ready_r    <= 1'b0;
      dump_req_r <= 1'b0;
      halted_r   <= 1'b0;
      bad_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      ret_r      <= ret_s;
      enable_r   <= (state_s == S_RUN) || (state_s == S_STEP_EXEC);
      ready_r    <= (state_s == S_READY) || (state_s == S_STEP_WAIT);
      dump_req_r <= (state_s == S_DUMP);
      halted_r   <= (state_s == S_DONE);
      bad_r      <= bad_s;
    end
  end

  // Saturating count of cycles during which the pipeline was enabled
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_r <= {CYCLE_CNT_WIDTH{1'b0}};
    end else if (enable_r && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.o_cmd_ready       = ready_r;
  assign bus.o_pipeline_enable = enable_r;
  assign bus.o_dump_request    = dump_req_r;
  assign bus.o_cycle_count     = count_r;
  assign bus.o_halted          = halted_r;
  assign bus.o_bad_cmd         = bad_r;

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
- Sequences execution of the pipelined CPU for the debug unit.
- After instruction memory is loaded, accepts a mode command (continuous or step) and gates the pipeline with a clock-enable.
- Counts executed cycles and requests a state dump (registers, data memory, latches) from the UART/pipeline interface after every step and at program end.
- Sits between the UART command path and the pipeline's global enable.

Parameters:
CMD_WIDTH, 8, width of command word from UART side
CYCLE_CNT_WIDTH, 32, width of executed-cycle counter
CMD_CONTINUOUS, 8'h43, command code: run until program finished
CMD_STEP, 8'h53, command code: enter step mode / execute one cycle
CMD_ABORT, 8'h41, command code: end step session without further execution

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous reset, active-low
i_cmd  in  CMD_WIDTH  command code, valid with i_cmd_valid
i_cmd_valid  in  1  one-cycle command strobe
i_load_done  in  1  one-cycle pulse: instruction memory fully written
i_program_finished  in  1  level: halt instruction reached WB
i_dump_done  in  1  one-cycle pulse: dump transmission complete
o_cmd_ready  out  1  controller accepts a command this cycle
o_pipeline_enable  out  1  pipeline clock-enable (registered)
o_dump_request  out  1  level request for state dump
o_cycle_count  out  CYCLE_CNT_WIDTH  cycles with enable asserted
o_halted  out  1  session finished (DONE state)
o_bad_cmd  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (i_reset=0, async): state IDLE; all outputs 0; counter 0. Release is synchronous to i_clk.
- All outputs are registered. o_cmd_ready=1 only in READY and STEP_WAIT.
- IDLE: wait for i_load_done, then go to READY. Commands in IDLE are rejected (o_bad_cmd pulse).
- READY:
  - CMD_CONTINUOUS -> RUN.
  - CMD_STEP -> STEP_WAIT. Entering step mode executes nothing.
  - Any other code -> o_bad_cmd, stay.
- RUN:
  - o_pipeline_enable=1 every cycle.
  - When i_program_finished is sampled 1: enable=0 from the next cycle, go to DUMP with return target DONE.
- STEP_WAIT:
  - CMD_STEP -> STEP_EXEC.
  - CMD_ABORT -> DUMP with return target DONE.
  - Other codes -> o_bad_cmd.
  - If i_program_finished is already 1 on entry -> DONE without a further dump (dump already issued).
- STEP_EXEC: o_pipeline_enable=1 for exactly one cycle, then DUMP.
  - Return target is DONE if i_program_finished=1 in that cycle, else STEP_WAIT.
- DUMP:
  - o_dump_request=1 from the entry cycle until i_dump_done is sampled.
  - Request drops the following cycle, then go to the return target.
  - i_dump_done outside DUMP is ignored.
- DONE: o_halted=1. All commands are rejected with o_bad_cmd. Only reset exits.
- Counter:
  - +1 on every cycle o_pipeline_enable=1.
  - Saturates at all-ones (no wrap).
  - Held, not cleared, across DUMP/STEP_WAIT.
- Simultaneous events:
  - i_cmd_valid while o_cmd_ready=0 -> rejected with o_bad_cmd (including during DUMP).
  - i_load_done outside IDLE is ignored.
- Reset mid-RUN or mid-DUMP: outputs clear immediately and asynchronously; enable and request drop without waiting for the clock.

Optional Feature:
Macro PIPE_CTRL_BREAKPOINT_EN.
- Defined:
  - Adds ports i_pc (32 bits, fetch PC), i_bp_addr (32 bits) and i_bp_valid (1 bit).
  - In RUN, when i_bp_valid=1 and i_pc==i_bp_addr: enable=0 next cycle, go to DUMP with return target STEP_WAIT; the user continues by stepping.
  - Breakpoint is checked only in RUN; i_program_finished takes priority over a breakpoint hit in the same cycle.
- Undefined: ports absent; RUN ends only on i_program_finished.

Test Plan:
- Reset then i_load_done, CMD 8'h43; i_program_finished rises after 10 enabled cycles -> o_pipeline_enable high exactly 10 cycles, o_cycle_count=10, o_dump_request high until i_dump_done, then o_halted=1.
- Load, CMD 8'h53, then three CMD 8'h53 each followed by i_dump_done after 5 cycles -> three 1-cycle enable pulses, three dump requests, o_cycle_count=3, state STEP_WAIT with o_cmd_ready=1.
- Step mode: on 2nd step i_program_finished=1 -> dump, then o_halted=1; next CMD 8'h53 -> o_bad_cmd pulse, no enable.
- CMD 8'h43 before i_load_done, and CMD 8'h55 in READY -> o_bad_cmd each time, state unchanged, enable stays 0.
- Drive i_reset low mid-RUN (cycle 4) -> o_pipeline_enable, o_cycle_count, o_dump_request 0 before the next clock edge; after release requires a new i_load_done.
- With PIPE_CTRL_BREAKPOINT_EN, i_bp_addr=32'h10, PC steps by 4 -> enable stops after the PC=0x10 cycle, dump requested, then STEP_WAIT and a CMD 8'h53 executes one cycle.
